// File: rtl/fpu_pkg.sv
// Shared FPU definitions: op-select encodings and the {OVFL,NaN,INF} flag layout.
package fpu_pkg;

    localparam logic [2:0] FPU_OP_ADD  = 3'd0;
    localparam logic [2:0] FPU_OP_SUB  = 3'd1;
    localparam logic [2:0] FPU_OP_MUL  = 3'd2;
    localparam logic [2:0] FPU_OP_DIV  = 3'd3;
    localparam logic [2:0] FPU_OP_SQRT = 3'd4;
    localparam logic [2:0] FPU_OP_CMP  = 3'd5;
    localparam logic [2:0] FPU_OP_I2F  = 3'd6;
    localparam logic [2:0] FPU_OP_F2I  = 3'd7;

    localparam int FLAG_W    = 3;
    localparam int FLAG_OVFL = 2;
    localparam int FLAG_NAN  = 1;
    localparam int FLAG_INF  = 0;

    typedef struct packed {
        logic ovfl;
        logic nan;
        logic inf;
    } fpu_flags_t;

    function automatic fpu_flags_t pack_flags(
        input logic ovfl,
        input logic nan,
        input logic inf
    );
        fpu_flags_t f;
        f.ovfl = ovfl;
        f.nan  = nan;
        f.inf  = inf;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to first request at/after ptr.
// ptr moves past the winner only when upd signals a transfer.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            NRST,
    input  logic [NREQ-1:0] req,
    input  logic            upd,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   winner
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] widx;
    logic          found;
    int            idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        widx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx  = (int'(ptr) + i) % NREQ;
            widx = PW'(idx);
            if (!found && req[widx]) begin
                found       = 1'b1;
                grant[widx] = 1'b1;
                winner      = widx;
            end
        end
    end

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            ptr <= '0;
        end else if (upd) begin
            if (winner == PW'(NREQ - 1))
                ptr <= '0;
            else
                ptr <= winner + PW'(1);
        end
    end

endmodule

// File: rtl/fpu_share_arb.sv
// Shares one fixed-latency FPU among NREQ requesters with tagged return routing.
// Optional sequencing check enabled by defining FPU_ARB_ERRCHK_EN.
module fpu_share_arb
    import fpu_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = 4,
    parameter  int DW   = 32,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               NRST,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*3-1:0]  req_sel,
    input  logic               hold,
    output logic [DW-1:0]      AIN,
    output logic [DW-1:0]      BIN,
    output logic [2:0]         sel,
    output logic               DI_VALID,
    input  logic [DW-1:0]      fpu_result,
    input  logic               DO_VALID,
    input  logic               OVFL,
    input  logic               NaN,
    input  logic               INF,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [2:0]         rsp_flags,
    output logic               err
);

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   winner;
    logic            xfer;
    logic [PW-1:0]   issue_tag;
    logic [LAT-1:0]  pv;
    logic [PW-1:0]   pt [LAT];
    logic            fire;
    fpu_flags_t      flags_in;

    assign arb_req   = hold ? '0 : req_valid;
    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .NRST   (NRST),
        .req    (arb_req),
        .upd    (xfer),
        .grant  (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            DI_VALID  <= 1'b0;
            AIN       <= '0;
            BIN       <= '0;
            sel       <= '0;
            issue_tag <= '0;
        end else begin
            DI_VALID <= xfer;
            if (xfer) begin
                AIN       <= req_a[int'(winner)*DW +: DW];
                BIN       <= req_b[int'(winner)*DW +: DW];
                sel       <= req_sel[int'(winner)*3 +: 3];
                issue_tag <= winner;
            end
        end
    end

    // Ownership pipe runs in lockstep with the FPU datapath.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++)
                pt[i] <= '0;
        end else begin
            pv[0] <= DI_VALID;
            pt[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pt[i] <= pt[i-1];
            end
        end
    end

    assign fire     = DO_VALID & pv[LAT-1];
    assign flags_in = pack_flags(OVFL, NaN, INF);

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            rsp_valid <= '0;
            if (fire) begin
                rsp_valid <= NREQ'(1) << pt[LAT-1];
                rsp_data  <= fpu_result;
                rsp_flags <= flags_in;
            end
        end
    end

`ifdef FPU_ARB_ERRCHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST)
            err_q <= 1'b0;
        else if (DO_VALID != pv[LAT-1])
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
